pipe_trace_buffer: RTL

//   Hardware trace recorder for the 5-stage pipeline. Captures one snapshot per enabled

---
 rtl/pipe_trace_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular trace recorder for the 5-stage pipeline.
// Captures {cyc,F,D,E,M,W} snapshots, freezes after a trigger plus POST_TRIG entries, then streams them oldest first.
module pipe_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int POST_TRIG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] instrF,
    input  logic [31:0] instrD,
    input  logic [31:0] instrE,
    input  logic [31:0] instrM,
    input  logic [31:0] instrW,
    input  logic        trig,
    input  logic        clear,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ARMED = 2'b00,
        POST  = 2'b01,
        DUMP  = 2'b10,
        DONE  = 2'b11
    } traceStateT;

    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_LAST = (AW+1)'(POST_TRIG - 1);
    localparam bit          NO_POST   = (POST_TRIG == 0);

    traceStateT    curState, nxtState;
    logic [31:0]   cyc;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic [AW:0]   postCnt;
    logic [AW:0]   entIdx;
    logic [2:0]    wordIdx;
    logic [31:0]   mem [DEPTH][6];

    logic capture;
    logic accepted;
    logic issue;
    logic lastWord;

    assign state    = curState;
    assign capture  = en && !clear && (curState == ARMED || curState == POST);
    assign accepted = rd_valid && rd_ready;
    // A new word is fetched whenever the output register is empty or being drained this cycle.
    assign issue    = (curState == DUMP) && !clear && (entIdx < count) && (!rd_valid || rd_ready);
    assign lastWord = (wordIdx == 3'd5) && (entIdx + ONE == count);
    assign rdPtr    = wrPtr - count[AW-1:0] + entIdx[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= ARMED;
        end else begin
            // NOTE: state elements use non-blocking assignment so every register samples pre-edge values.
            curState <= nxtState;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no branch leaves nxtState unassigned and infers a latch.
        nxtState = curState;
        if (clear) begin
            nxtState = ARMED;
        end else begin
            case (curState)
                ARMED:   if (trig) nxtState = NO_POST ? DUMP : POST;
                POST:    if (en && postCnt == POST_LAST) nxtState = DUMP;
                DUMP:    if (count == '0 || (accepted && rd_last)) nxtState = DONE;
                DONE:    nxtState = DONE;
                default: nxtState = ARMED;
            endcase
        end
    end

    // NOTE: the snapshot array has no reset; an entry is only read after it has been written since the last clear.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wrPtr][0] <= cyc;
            mem[wrPtr][1] <= instrF;
            mem[wrPtr][2] <= instrD;
            mem[wrPtr][3] <= instrE;
            mem[wrPtr][4] <= instrM;
            mem[wrPtr][5] <= instrW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc      <= '0;
            wrPtr    <= '0;
            count    <= '0;
            postCnt  <= '0;
            entIdx   <= '0;
            wordIdx  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            cyc <= cyc + 32'd1;
            if (clear) begin
                wrPtr    <= '0;
                count    <= '0;
                postCnt  <= '0;
                entIdx   <= '0;
                wordIdx  <= '0;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                if (capture) begin
                    wrPtr <= wrPtr + AW'(1);
                    if (count != FULL) count <= count + ONE;
                end

                if (curState == ARMED && trig) begin
                    postCnt <= '0;
                end else if (curState == POST && en) begin
                    postCnt <= postCnt + ONE;
                end

                if (issue) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rdPtr][wordIdx];
                    rd_last  <= lastWord;
                    if (wordIdx == 3'd5) begin
                        wordIdx <= '0;
                        entIdx  <= entIdx + ONE;
                    end else begin
                        wordIdx <= wordIdx + 3'd1;
                    end
                end else if (accepted) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end

                if (curState != DUMP) begin
                    entIdx  <= '0;
                    wordIdx <= '0;
                end
            end
        end
    end

endmodule
